// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with a 3-sample
// majority vote, and a byte output on a valid/ready port.
//
// Handshake: valid stays high, and data stays stable, until a cycle with
// valid && ready. A byte that completes in that same cycle replaces the
// accepted one and valid stays high. A byte that completes while
// valid && !ready is dropped and overrun pulses for one cycle.
module uart_rx #(
  parameter int F_CLK   = 48_000_000,
  parameter int BAUD    = 115_200,
  parameter int OVS_DIV = F_CLK / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int PW = (OVS_DIV < 2) ? 1 : $clog2(OVS_DIV);

  if (OVS_DIV < 2) begin : g_bad_div
    $error("uart_rx: OVS_DIV must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // state is kept as a plainly named register so checkers can bind to it
  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [PW-1:0]   presc;
  logic [3:0]      cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            samp7, samp8;
  logic            tick, maj;
  logic            shift_en, bit_inc, deliver, ferr_set;

  assign tick = (presc == PW'(OVS_DIV - 1));
  // third vote is the live sample at the count-9 tick
  assign maj  = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  assign busy = (state != IDLE);

  // Synchronizer; both flops reset high so reset cannot look like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-tick strobes for the datapath
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    bit_inc    = 1'b0;
    deliver    = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (tick) begin
          if (cnt == 4'd9 && maj) state_next = IDLE;   // too short: glitch
          else if (cnt == 4'd15)  state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt == 4'd9) shift_en = 1'b1;
          if (cnt == 4'd15) begin
            if (bit_idx == 3'd7) state_next = STOP;
            else                 bit_inc    = 1'b1;
          end
        end
      end
      STOP: begin
        // decide mid stop bit so back-to-back frames are not missed
        if (tick && cnt == 4'd9) begin
          if (maj) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler and sample counter; held clear in IDLE so ticks align to the start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
      samp7 <= 1'b0;
      samp8 <= 1'b0;
    end else if (state == IDLE) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + 4'd1;
      if (cnt == 4'd7) samp7 <= rx_s;
      if (cnt == 4'd8) samp8 <= rx_s;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE) bit_idx <= '0;
      else if (bit_inc)  bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {maj, shreg[7:1]};
    end
  end

  // Output register, handshake and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 32 clocks per bit (OVS_DIV = 2). Inputs change on the
// falling edge; the monitor samples 1 ns after the falling edge.
module tb_uart_rx;

  localparam int BIT_CLK = 32;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .F_CLK (3_200_000),
    .BAUD  (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int fe_cnt, ov_cnt, vrise_cnt, vhigh_cnt;
  int stop_cyc, rise_cyc, ov_cyc;
  logic prev_valid = 1'b0;
  event stop_ev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    fe_cnt    = 0;
    ov_cnt    = 0;
    vrise_cnt = 0;
    vhigh_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits);
    @(negedge clk);
    rxd = 1'b0;
    idle_clks(BIT_CLK - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rxd = b[i];
      idle_clks(BIT_CLK - 1);
    end
    @(negedge clk);
    rxd = stop_v;
    stop_cyc = cyc;
    -> stop_ev;
    idle_clks(BIT_CLK * stop_bits - 1);
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, 1);
  endtask

  // ---------------- monitor: pulse counters and output scoreboard ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (frame_err) fe_cnt++;
        if (overrun) begin
          ov_cnt++;
          ov_cyc = cyc;
        end
        if (valid && !prev_valid) begin
          vrise_cnt++;
          rise_cyc = cyc;
        end
        if (valid) vhigh_cnt++;
        if (valid && ready) begin
          check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check_eq("rx_data", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0] rb;
    rst   = 1'b1;
    rxd   = 1'b1;
    ready = 1'b1;
    clear_counts();
    idle_clks(3);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle_clks(BIT_CLK);

    // nominal 0x55 with ready held high
    clear_counts();
    send_byte(8'h55);
    idle_clks(BIT_CLK);
    check_eq("nom_valid_cycles", 32'(vhigh_cnt), 32'd1);
    check_eq("nom_frame_err", 32'(fe_cnt), 32'd0);
    check_eq("nom_overrun", 32'(ov_cnt), 32'd0);
    check_eq("nom_latency_window", 32'((rise_cyc - stop_cyc) >= 19 && (rise_cyc - stop_cyc) <= 24), 32'd1);
    check_eq("nom_before_stop_end", 32'((rise_cyc - stop_cyc) < BIT_CLK), 32'd1);
    check_eq("nom_q_drained", 32'(exp_q.size()), 32'd0);

    // a few random bytes back to back
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
    end
    idle_clks(BIT_CLK);
    check_eq("rand_q_drained", 32'(exp_q.size()), 32'd0);

    // glitch: 8 clocks low must not start a frame
    clear_counts();
    @(negedge clk);
    rxd = 1'b0;
    idle_clks(4);
    check_eq("glitch_busy_high", 32'(busy), 32'd1);
    idle_clks(4);
    rxd = 1'b1;
    idle_clks(32);
    check_eq("glitch_busy_low", 32'(busy), 32'd0);
    check_eq("glitch_no_valid", 32'(vrise_cnt), 32'd0);
    check_eq("glitch_no_ferr", 32'(fe_cnt), 32'd0);
    send_byte(8'hC3);
    idle_clks(BIT_CLK);

    // framing error: stop bit low and line held low for 3 bit times
    clear_counts();
    send_frame(8'hA3, 1'b0, 3);
    check_eq("ferr_busy_while_low", 32'(busy), 32'd1);
    idle_clks(BIT_CLK);
    check_eq("ferr_busy_released", 32'(busy), 32'd0);
    check_eq("ferr_pulse_count", 32'(fe_cnt), 32'd1);
    check_eq("ferr_no_valid", 32'(vrise_cnt), 32'd0);
    send_byte(8'h3C);
    idle_clks(BIT_CLK);
    check_eq("ferr_q_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: second byte dropped with one overrun pulse
    clear_counts();
    ready = 1'b0;
    send_byte(8'h12);
    send_frame(8'h34, 1'b1, 1);
    idle_clks(BIT_CLK);
    check_eq("ovr_pulse_count", 32'(ov_cnt), 32'd1);
    check_eq("ovr_in_stop_bit", 32'((ov_cyc - stop_cyc) < BIT_CLK), 32'd1);
    check_eq("ovr_valid_held", 32'(valid), 32'd1);
    check_eq("ovr_data_kept", 32'(data), 32'h12);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_eq("ovr_valid_cleared", 32'(valid), 32'd0);
    idle_clks(BIT_CLK);

    // simultaneous accept and delivery
    clear_counts();
    send_byte(8'h12);
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h34, 1'b1, 1);
      begin
        @(stop_ev);
        repeat (22) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    idle_clks(8);
    check_eq("simul_no_overrun", 32'(ov_cnt), 32'd0);
    check_eq("simul_valid_held", 32'(valid), 32'd1);
    check_eq("simul_data_new", 32'(data), 32'h34);
    ready = 1'b1;
    idle_clks(BIT_CLK);
    check_eq("simul_q_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-frame after 4 data bits of 0xAA
    clear_counts();
    rb = 8'hAA;
    @(negedge clk);
    rxd = 1'b0;
    idle_clks(BIT_CLK - 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rxd = rb[i];
      idle_clks(BIT_CLK - 1);
    end
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_data", 32'(data), 32'h0);
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ovr", 32'(overrun), 32'd0);
    idle_clks(3 * BIT_CLK);
    check_eq("mid_rst_no_pulses", 32'(vrise_cnt + fe_cnt + ov_cnt), 32'd0);
    send_byte(8'hF0);
    idle_clks(BIT_CLK);

    check_eq("final_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
